// File: rtl/fmaarb.sv
// fmaarb: issue arbiter and stage-occupancy tracker for the shared FMA pipe.
// Define FMAARB_FAIR_EN to enable the requester-1 starvation counter.
module fmaarb #(
  parameter int OPW    = 3,
  parameter int LAT    = 3,
  parameter int STARVE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           Req0Valid,
  input  logic [OPW-1:0] Req0Op,
  output logic           Req0Ready,
  input  logic           Req1Valid,
  input  logic [OPW-1:0] Req1Op,
  output logic           Req1Ready,
  input  logic           Flush0,
  output logic           FmaIssue,
  output logic           FmaSel,
  output logic [OPW-1:0] FmaOp,
  output logic           FmaEn,
  output logic           Res0Valid,
  input  logic           Res0Ready,
  output logic           Res1Valid,
  input  logic           Res1Ready,
  output logic           Busy
);

  logic [LAT:1] v, t, vn, tn;
  logic         stall, en, elig0, win0, win1, starved;

  assign stall = v[LAT] & ~(t[LAT] ? Res1Ready : Res0Ready);
  assign en    = ~stall;
  assign elig0 = Req0Valid & ~Flush0;

`ifdef FMAARB_FAIR_EN
  localparam int CW = $clog2(STARVE + 1);
  logic [CW-1:0] cnt;

  assign starved = (cnt == CW'(STARVE));

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (!Req1Valid || (win1 && en))
      cnt <= '0;
    else if (win0 && en && !starved)
      cnt <= cnt + CW'(1);
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (elig0 && Req1Valid) begin
      win0 = ~starved;
      win1 = starved;
    end else begin
      win0 = elig0;
      win1 = Req1Valid;
    end
  end

  assign FmaEn     = en;
  assign FmaIssue  = (win0 | win1) & en;
  assign FmaSel    = win1;
  assign FmaOp     = FmaIssue ? (win1 ? Req1Op : Req0Op) : '0;
  assign Req0Ready = win0 & en;
  assign Req1Ready = win1 & en;
  assign Res0Valid = v[LAT] & ~t[LAT] & ~Flush0;
  assign Res1Valid = v[LAT] & t[LAT];
  assign Busy      = |v;

  // Flush kills requester-0 stages after the shift, frozen or not.
  always_comb begin
    vn = v;
    tn = t;
    if (en) begin
      vn = {v[LAT-1:1], FmaIssue};
      tn = {t[LAT-1:1], FmaSel};
    end
    if (Flush0)
      vn = vn & tn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      t <= '0;
    end else begin
      v <= vn;
      t <= tn;
    end
  end

endmodule

// File: tb/tb_fmaarb.sv
// tb_fmaarb: directed checks of fmaarb grant, pipeline tracking,
// backpressure, flush and reset behaviour (LAT=3, STARVE=4).
module tb_fmaarb;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Req0Valid = 0, Req1Valid = 0, Flush0 = 0;
  logic [2:0] Req0Op = 0, Req1Op = 0;
  logic       Res0Ready = 1, Res1Ready = 1;
  logic       Req0Ready, Req1Ready, FmaIssue, FmaSel, FmaEn;
  logic       Res0Valid, Res1Valid, Busy;
  logic [2:0] FmaOp;
  int         ncmp = 0;
  int         nerr = 0;

  fmaarb #(.OPW(3), .LAT(3), .STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .Req0Valid(Req0Valid), .Req0Op(Req0Op), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Op(Req1Op), .Req1Ready(Req1Ready),
    .Flush0(Flush0), .FmaIssue(FmaIssue), .FmaSel(FmaSel),
    .FmaOp(FmaOp), .FmaEn(FmaEn),
    .Res0Valid(Res0Valid), .Res0Ready(Res0Ready),
    .Res1Valid(Res1Valid), .Res1Ready(Res1Ready), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Req0Valid = 0; Req1Valid = 0; Flush0 = 0;
      Res0Ready = 1; Res1Ready = 1; reset = 0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    ncmp++;
    if ({Req0Ready, Req1Ready, FmaIssue, FmaSel, FmaOp, FmaEn,
         Res0Valid, Res1Valid, Busy} !== 11'b000_0000_1000) begin
      nerr++;
      $display("FAIL reset_outputs got r0r=%b r1r=%b iss=%b sel=%b op=%0d en=%b v0=%b v1=%b busy=%b want all 0 except en=1",
               Req0Ready, Req1Ready, FmaIssue, FmaSel, FmaOp, FmaEn,
               Res0Valid, Res1Valid, Busy);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    Req0Valid = 1; Req0Op = 3'b101;
    #1;
    ncmp++;
    if ({Req0Ready, FmaIssue, FmaSel, FmaOp, Busy} !== 7'b11_0_101_0) begin
      nerr++;
      $display("FAIL single_issue got rdy=%b iss=%b sel=%b op=%0d busy=%b want 1 1 0 5 0",
               Req0Ready, FmaIssue, FmaSel, FmaOp, Busy);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      Req0Valid = 0;
      #1;
      ncmp++;
      if ({Res0Valid, Busy, FmaOp} !== {c == 3, c <= 3, 3'd0}) begin
        nerr++;
        $display("FAIL single_c%0d got v0=%b busy=%b op=%0d want v0=%b busy=%b op=0",
                 c, Res0Valid, Busy, FmaOp, c == 3, c <= 3);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] g;
`ifdef FMAARB_FAIR_EN
    g = 10'b10_0001_0000;
`else
    g = 10'b00_0000_0000;
`endif
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      Req0Valid = (c < 10); Req0Op = 3'd2;
      Req1Valid = (c < 10); Req1Op = 3'd6;
      #1;
      if (c < 10) begin
        ncmp++;
        if ({Req0Ready, Req1Ready, FmaSel, FmaOp} !==
            {!g[c], g[c], g[c], g[c] ? 3'd6 : 3'd2}) begin
          nerr++;
          $display("FAIL b2b_grant_c%0d got r0=%b r1=%b sel=%b op=%0d want owner %0d",
                   c, Req0Ready, Req1Ready, FmaSel, FmaOp, g[c]);
        end
      end
      if (c >= 3) begin
        ncmp++;
        if ({Res0Valid, Res1Valid} !== {!g[c-3], g[c-3]}) begin
          nerr++;
          $display("FAIL b2b_result_c%0d got v0=%b v1=%b want v0=%b v1=%b",
                   c, Res0Valid, Res1Valid, !g[c-3], g[c-3]);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    logic [8:0] ev0, een;
    ev0 = 9'b0_1111_1000;
    een = 9'b1_1110_0111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      Req0Valid = (c < 3); Req0Op = 3'(c + 1);
      Req1Valid = (c == 3 || c == 4);
      Res0Ready = !(c == 3 || c == 4);
      #1;
      ncmp++;
      if ({Res0Valid, FmaEn, Busy} !== {ev0[c], een[c], c >= 1 && c <= 7}) begin
        nerr++;
        $display("FAIL bp_c%0d got v0=%b en=%b busy=%b want v0=%b en=%b busy=%b",
                 c, Res0Valid, FmaEn, Busy, ev0[c], een[c], c >= 1 && c <= 7);
      end
      if (c == 3 || c == 4) begin
        ncmp++;
        if ({Req0Ready, Req1Ready, FmaIssue} !== 3'b000) begin
          nerr++;
          $display("FAIL bp_ready_c%0d got r0=%b r1=%b iss=%b want 000",
                   c, Req0Ready, Req1Ready, FmaIssue);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_flush;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      Req0Valid = (c == 0 || c == 2 || c == 3);
      Req1Valid = (c == 1);
      Flush0 = (c == 3);
      #1;
      if (c == 1) begin
        ncmp++;
        if ({Req1Ready, FmaSel, Req0Ready} !== 3'b110) begin
          nerr++;
          $display("FAIL flush_r1grant got r1=%b sel=%b r0=%b want 1 1 0",
                   Req1Ready, FmaSel, Req0Ready);
        end
      end
      if (c == 3) begin
        ncmp++;
        if ({Req0Ready, FmaIssue, Res0Valid} !== 3'b000) begin
          nerr++;
          $display("FAIL flush_cycle got r0=%b iss=%b v0=%b want 000",
                   Req0Ready, FmaIssue, Res0Valid);
        end
      end
      if (c >= 4) begin
        ncmp++;
        if ({Res0Valid, Res1Valid, Busy} !== {1'b0, c == 4, c == 4}) begin
          nerr++;
          $display("FAIL flush_c%0d got v0=%b v1=%b busy=%b want 0 %b %b",
                   c, Res0Valid, Res1Valid, Busy, c == 4, c == 4);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_flush_stall;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      Req0Valid = (c == 0);
      Res0Ready = (c != 3);
      Flush0 = (c == 3);
      #1;
      if (c == 3) begin
        ncmp++;
        if ({Res0Valid, FmaEn} !== 2'b00) begin
          nerr++;
          $display("FAIL flushstall_c3 got v0=%b en=%b want 0 0",
                   Res0Valid, FmaEn);
        end
      end
      if (c >= 4) begin
        ncmp++;
        if ({Res0Valid, FmaEn, Busy} !== 3'b010) begin
          nerr++;
          $display("FAIL flushstall_c%0d got v0=%b en=%b busy=%b want 0 1 0",
                   c, Res0Valid, FmaEn, Busy);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      Req0Valid = (c < 3);
      reset = (c == 3);
      #1;
      if (c == 2) begin
        ncmp++;
        if (Busy !== 1'b1) begin
          nerr++;
          $display("FAIL rstmid_busy got %b want 1", Busy);
        end
      end
      if (c >= 4) begin
        ncmp++;
        if ({Res0Valid, Res1Valid, Busy, FmaEn} !== 4'b0001) begin
          nerr++;
          $display("FAIL rstmid_c%0d got v0=%b v1=%b busy=%b en=%b want 0 0 0 1",
                   c, Res0Valid, Res1Valid, Busy, FmaEn);
        end
      end
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_single;
    idle(2);
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_flush_stall;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fmaarb.md
# fmaarb

Issue arbiter and pipeline-occupancy controller for the shared FMA unit. Two requesters, the FPU execute path (requester 0) and the divide/square-root iteration path (requester 1), share a single LAT-stage FMA pipeline: alignment, multiply/add, then normalize/round. The block selects one operation per cycle, drives the operand-select and advance controls of the FMA datapath, tracks which requester owns each in-flight stage, and routes each completed result back to its owner with backpressure and flush support.

## Interface
Parameters:
- OPW, 3: width of the FMA operation code forwarded to the datapath.
- LAT, 3: number of FMA pipeline stages. Must be at least 2.
- STARVE, 4: number of consecutive requester-0 wins while requester 1 waits before requester 1 is forced in. Must be at least 1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- Req0Valid, input, 1: requester 0 has an operation.
- Req0Op, input, OPW: requester 0 opcode.
- Req0Ready, output, 1: requester 0 operation accepted this cycle.
- Req1Valid, input, 1: requester 1 has an operation.
- Req1Op, input, OPW: requester 1 opcode.
- Req1Ready, output, 1: requester 1 operation accepted this cycle.
- Flush0, input, 1: kill all requester-0 operations, both in flight and offered.
- FmaIssue, output, 1: a new operation enters stage 1 at the next edge.
- FmaSel, output, 1: operand-mux select for the alignment stage (0 = requester 0, 1 = requester 1).
- FmaOp, output, OPW: opcode of the issued operation. Value is 0 when FmaIssue is 0.
- FmaEn, output, 1: pipeline advance enable for all FMA stage registers.
- Res0Valid, output, 1: final stage holds a live requester-0 result.
- Res0Ready, input, 1: requester 0 accepts its result.
- Res1Valid, output, 1: final stage holds a live requester-1 result.
- Res1Ready, input, 1: requester 1 accepts its result.
- Busy, output, 1: at least one stage is valid.

## Operation
State:
- V[1..LAT] holds a valid bit per stage.
- T[1..LAT] holds an owner tag per stage.
- StarveCnt is a counter of width clog2(STARVE+1).

Backpressure:
- Stall = V[LAT] & ~(T[LAT] ? Res1Ready : Res0Ready).
- FmaEn = ~Stall. The whole pipeline freezes on a stall; there are no bubbles to collapse.

Results:
- Res0Valid = V[LAT] & ~T[LAT] & ~Flush0.
- Res1Valid = V[LAT] & T[LAT].

Grant (combinational):
- Eligible0 = Req0Valid & ~Flush0.
- If only one requester is eligible or valid, that requester wins.
- If both are, requester 0 wins unless StarveCnt == STARVE, in which case requester 1 wins.
- FmaIssue = (win0 | win1) & FmaEn.
- Req0Ready = win0 & FmaEn. Req1Ready = win1 & FmaEn. FmaSel = win1.

On a clock edge with FmaEn = 1:
- Stages shift: V[k+1] <= V[k], T[k+1] <= T[k].
- Stage 1 loads V[1] <= FmaIssue and T[1] <= FmaSel.

Flush0 (same edge, applies regardless of FmaEn):
- Every stage with T = 0 has V cleared. Requester-1 stages are untouched.

StarveCnt:
- Increments (saturating at STARVE) when win0 & FmaEn & Req1Valid.
- Clears when win1 & FmaEn, or when Req1Valid = 0.
- Holds otherwise, including during a stall.

Simultaneous events:
- Flush0 during a stall whose final stage is requester 0: that stage is cleared, so the stall ends the next cycle.
- Result accept and new issue in the same cycle are allowed; this gives full throughput of 1 op/cycle.

## Timing
- Reset values: V = 0, T = 0, StarveCnt = 0. All outputs are 0 except FmaEn = 1 (Stall = 0 because V = 0).
- Reset applied mid-operation discards all in-flight operations. No result is produced for them.
- Latency: an operation accepted (Ready = 1) in cycle N presents ResValid in cycle N+LAT with no stalls. Each stall cycle adds 1.
- Ready/Valid/Stall paths are combinational. State registers update only on the rising edge of clk.

## Configuration
- FMAARB_FAIR_EN defined: starvation counter present, as described above.
- FMAARB_FAIR_EN undefined: strict priority to requester 0. StarveCnt is removed and requester 1 wins only when Eligible0 = 0.

## Test plan
- Single op, LAT=3: Req0Valid=1 with Req0Op=3'b101 for one cycle, Res0Ready=1 -> Req0Ready=1 and FmaOp=5 in cycle 0; Res0Valid=1 in cycle 3 only; Busy high in cycles 1–3.
- Back-to-back both requesters, STARVE=4, fairness on: both valid for 10 cycles -> grant order 0,0,0,0,1,0,0,0,0,1. With the macro off -> ten requester-0 grants.
- Backpressure: 3 ops issued, Res0Ready=0 for 2 cycles when the first reaches stage 3 -> FmaEn=0 and Req Ready=0 for those 2 cycles; results emerge in order with no loss or duplication.
- Flush: tags in stages 1..3 = 0,1,0 and Flush0=1 -> next cycle only the requester-1 op remains, which then emerges as Res1Valid exactly once; Req0Ready=0 in the flush cycle.
- Flush during stall: stage 3 holds requester 0, Res0Ready=0, Flush0=1 -> Res0Valid=0 that cycle; FmaEn=1 the following cycle.
- Reset mid-flight: 3 ops in flight, reset=1 for one cycle -> all Valid outputs 0, Busy=0, FmaEn=1, and no result ever appears.
